// File: rtl/sha256_byte_host.sv
// sha256_byte_host
// Host-side driver for the byte-serial SHA-256 core. Collects a message from
// the system side, bursts it into the core as one gapless strobe run, then
// captures the 32 returned digest bytes and serves them on a read port.

module sha256_byte_host #(
    parameter int MAX_LEN = 55,
    parameter int TIMEOUT = 4095,
    parameter int TO_W    = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] core_byte,
    output logic       core_strobe,
    input  logic [7:0] core_dout,
    input  logic       core_dvalid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_CAPT = 2'd3;

    localparam logic [5:0]      MAX_L   = 6'(MAX_LEN);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_LEN   = 2'd1;
    localparam logic [1:0] E_TMO   = 2'd2;
    localparam logic [1:0] E_TRUNC = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [5:0]      len_q, len_d;
    logic [5:0]      idx_q, idx_d;
    logic [4:0]      k_q, k_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [7:0]      byte_q, byte_d;
    logic            strobe_q, strobe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      errc_q, errc_d;

    logic [7:0] msg_q [64];
    logic [7:0] dig_q [32];

    logic       wr_accept;
    logic [5:0] len_eff;
    logic       dig_we;
    logic [4:0] dig_waddr;

    assign wr_ready  = (state_q == S_IDLE) && (len_q < MAX_L);
    assign wr_accept = wr_valid && wr_ready;
    assign len_eff   = len_q + {5'd0, wr_accept};

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = errc_q;
    assign core_byte   = byte_q;
    assign core_strobe = strobe_q;
    assign rd_data     = dig_q[rd_addr];

    // Next-state logic: message collection, strobe burst, digest wait and capture
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        k_d       = k_q;
        timer_d   = timer_q;
        byte_d    = byte_q;
        strobe_d  = strobe_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        errc_d    = errc_q;
        dig_we    = 1'b0;
        dig_waddr = 5'd0;

        case (state_q)
            S_IDLE: begin
                if (wr_accept) begin
                    len_d = len_eff;
                end
                if (start) begin
                    if (len_eff == 6'd0) begin
                        err_d  = 1'b1;
                        errc_d = E_LEN;
                    end else begin
                        // A byte written alongside start into an empty buffer is byte 0
                        state_d  = S_SEND;
                        len_d    = len_eff;
                        done_d   = 1'b0;
                        err_d    = 1'b0;
                        errc_d   = E_NONE;
                        busy_d   = 1'b1;
                        strobe_d = 1'b1;
                        byte_d   = (len_q == 6'd0) ? wr_data : msg_q[0];
                        idx_d    = 6'd1;
                    end
                end
            end
            S_SEND: begin
                if (idx_q < len_q) begin
                    byte_d = msg_q[idx_q];
                    idx_d  = idx_q + 6'd1;
                end else begin
                    strobe_d = 1'b0;
                    byte_d   = 8'd0;
                    timer_d  = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_dvalid) begin
                    dig_we    = 1'b1;
                    dig_waddr = 5'd0;
                    k_d       = 5'd1;
                    state_d   = S_CAPT;
                end else if (timer_q == TO_LAST) begin
                    err_d   = 1'b1;
                    errc_d  = E_TMO;
                    len_d   = 6'd0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                if (core_dvalid) begin
                    dig_we    = 1'b1;
                    dig_waddr = k_q;
                    if (k_q == 5'd31) begin
                        done_d  = 1'b1;
                        len_d   = 6'd0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end else begin
                    err_d   = 1'b1;
                    errc_d  = E_TRUNC;
                    done_d  = 1'b0;
                    len_d   = 6'd0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Control registers and digest buffer, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= 6'd0;
            idx_q    <= 6'd0;
            k_q      <= 5'd0;
            timer_q  <= '0;
            byte_q   <= 8'd0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            errc_q   <= E_NONE;
            for (int i = 0; i < 32; i++) begin
                dig_q[i] <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            k_q      <= k_d;
            timer_q  <= timer_d;
            byte_q   <= byte_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            errc_q   <= errc_d;
            if (dig_we) begin
                dig_q[dig_waddr] <= core_dout;
            end
        end
    end

    // Message buffer needs no reset; len decides which entries are meaningful
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            msg_q[len_q] <= wr_data;
        end
    end

endmodule
